load_store_unit: RTL

- Multi-cycle data-memory access unit between the datapath and the data memory.
- Executes lb/lh/lw/lbu/lhu/sb/sh/sw with a request/ready handshake on the memory side.
- Generates byte enables and lane-replicated store data.
- Returns sign- or zero-extended load data, which drives the memory-read-data input (select 01) of the register-file write-back select.

---
 rtl/load_store_unit.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: formats byte/half/word accesses onto a request/ready memory port.
// Optional: define MISALIGN_TRAP_EN to reject misaligned halfword/word accesses instead of dropping low address bits.
module load_store_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             we,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] rdata,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [3:0]       mem_be,
  input  logic             mem_ready,
  input  logic [WIDTH-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, FIN} state_t;

  state_t           state;
  logic             lat_we;
  logic [2:0]       lat_f3;
  logic [1:0]       lat_off;
  logic             legal;
  logic [3:0]       st_be;
  logic [WIDTH-1:0] st_wd;
  logic [WIDTH-1:0] ld_val;
  logic [7:0]       ld_b;
  logic [15:0]      ld_h;

  assign busy = (state != IDLE);

  always_comb begin
    legal = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !we;
      default:                legal = 1'b0;
    endcase
`ifdef MISALIGN_TRAP_EN
    if (funct3[1:0] == 2'b01 && addr[0])          legal = 1'b0;
    if (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00) legal = 1'b0;
`endif
  end

  // Loads always fetch the whole word; lane selection happens on the way back.
  always_comb begin
    st_be = 4'b1111;
    st_wd = wdata;
    if (we) begin
      case (funct3[1:0])
        2'b00: begin
          st_be = 4'b0001 << addr[1:0];
          st_wd = {4{wdata[7:0]}};
        end
        2'b01: begin
          st_be = 4'b0011 << {addr[1], 1'b0};
          st_wd = {2{wdata[15:0]}};
        end
        default: begin
          st_be = 4'b1111;
          st_wd = wdata;
        end
      endcase
    end
  end

  always_comb begin
    ld_b   = mem_rdata[{lat_off, 3'b000} +: 8];
    ld_h   = lat_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_val = mem_rdata;
    case (lat_f3)
      3'b000:  ld_val = {{24{ld_b[7]}}, ld_b};
      3'b001:  ld_val = {{16{ld_h[15]}}, ld_h};
      3'b100:  ld_val = {24'd0, ld_b};
      3'b101:  ld_val = {16'd0, ld_h};
      default: ld_val = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      done      <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= 4'b0000;
      lat_we    <= 1'b0;
      lat_f3    <= 3'b000;
      lat_off   <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (start) begin
            lat_we  <= we;
            lat_f3  <= funct3;
            lat_off <= addr[1:0];
            if (legal) begin
              state     <= REQ;
              mem_req   <= 1'b1;
              mem_we    <= we;
              mem_addr  <= {addr[WIDTH-1:2], 2'b00};
              mem_be    <= st_be;
              mem_wdata <= st_wd;
            end else begin
              // Rejected: skip the memory entirely and report on the next cycle.
              state <= FIN;
              done  <= 1'b1;
              err   <= 1'b1;
            end
          end
        end
        REQ: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (!lat_we) rdata <= ld_val;
            state <= FIN;
            done  <= 1'b1;
            err   <= 1'b0;
          end
        end
        FIN: begin
          done  <= 1'b0;
          err   <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
